// File: rtl/mcp_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mcp_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADR   = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_IMM_EXEC  = 4'd9,
    ST_IMM_WB    = 4'd10,
    ST_JUMP      = 4'd11,
    ST_JAL       = 4'd12,
    ST_TRAP      = 4'd13
  } state_t;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation select
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_BRANCH = 2'b11;

  // Register file destination select
  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  // Register file write-data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_DATA   = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/mcp_mem_wait_timer.sv
// Memory-ready qualification and wait-cycle timeout for the control FSM.
// The count runs only while a memory state sees rdy low; any other cycle
// clears it, so each memory state starts counting from zero.
module mcp_mem_wait_timer #(
  parameter bit          MEM_HANDSHAKE  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic in_mem_i,
  input  logic mem_ready_i,
  output logic rdy_o,
  output logic expired_o
);

  // Counter holds at most TIMEOUT_CYCLES-1 before the FSM leaves for TRAP
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt_q, cnt_d;

  assign rdy_o = mem_ready_i | ~MEM_HANDSHAKE;

  // The current cycle is the last allowed wait cycle and memory still stalls
  assign expired_o = TIMEOUT_EN && in_mem_i && !rdy_o && (cnt_q == LIMIT);

  // Next count: clear outside memory states, on ready, or when disabled
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!in_mem_i || rdy_o || !TIMEOUT_EN || expired_o) begin
      cnt_d = '0;
    end
  end

  // Wait-cycle counter register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mcp_controller_fsm_v2.sv
// Second-generation multicycle MIPS control FSM with memory handshake,
// timeout trap and retired-instruction counter. Outputs are Moore except
// ir_write/pc_write in FETCH, which wait for a qualified memory ready.
module mcp_controller_fsm_v2 #(
  parameter bit          MEM_HANDSHAKE  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [5:0]       op_i6,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             instr_or_data_o,
  output logic             ir_write_o,
  output logic             mem_write_o,
  output logic             pc_write_o,
  output logic             branch_o,
  output logic             branch_ne_o,
  output logic             reg_write_o,
  output logic [1:0]       reg_dst_o2,
  output logic [1:0]       mem_to_reg_o2,
  output logic [1:0]       pc_src_o2,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o2,
  output logic [2:0]       alu_op_o3,
  output logic             imm_zext_o,
  output logic             trap_o,
  output logic [3:0]       state_o4,
  output logic [CNT_W-1:0] retired_o
);
  import mcp_pkg::*;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             in_mem, rdy, expired, retire;

  assign in_mem = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                  (state_q == ST_MEM_WRITE);

  mcp_mem_wait_timer #(
    .MEM_HANDSHAKE  (MEM_HANDSHAKE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_mem_i    (in_mem),
    .mem_ready_i (mem_ready_i),
    .rdy_o       (rdy),
    .expired_o   (expired)
  );

  // Next-state and control decode; every control defaults to 0
  always_comb begin
    state_d         = state_q;
    retire          = 1'b0;
    mem_req_o       = 1'b0;
    instr_or_data_o = 1'b0;
    ir_write_o      = 1'b0;
    mem_write_o     = 1'b0;
    pc_write_o      = 1'b0;
    branch_o        = 1'b0;
    branch_ne_o     = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o2      = REG_DST_RT;
    mem_to_reg_o2   = M2R_ALUOUT;
    pc_src_o2       = PC_SRC_ALU;
    alu_src_a_o     = 1'b0;
    alu_src_b_o2    = SRC_B_REG;
    alu_op_o3       = ALU_ADD;
    imm_zext_o      = 1'b0;
    trap_o          = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o2 = SRC_B_FOUR;
        ir_write_o   = rdy;
        pc_write_o   = rdy;
        if (expired)  state_d = ST_TRAP;
        else if (rdy) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b_o2 = SRC_B_BRANCH;
        case (op_i6)
          OP_LW, OP_SW:                      state_d = ST_MEM_ADR;
          OP_RTYPE:                          state_d = ST_EXECUTE;
          OP_BEQ, OP_BNE:                    state_d = ST_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = ST_IMM_EXEC;
          OP_J:                              state_d = ST_JUMP;
          OP_JAL:                            state_d = ST_JAL;
          default:                           state_d = ST_TRAP;
        endcase
      end
      ST_MEM_ADR: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = SRC_B_IMM;
        state_d      = (op_i6 == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        mem_req_o       = 1'b1;
        instr_or_data_o = 1'b1;
        if (expired)  state_d = ST_TRAP;
        else if (rdy) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write_o   = 1'b1;
        mem_to_reg_o2 = M2R_DATA;
        retire        = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        mem_req_o       = 1'b1;
        instr_or_data_o = 1'b1;
        mem_write_o     = 1'b1;
        if (expired) begin
          state_d = ST_TRAP;
        end else if (rdy) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_op_o3   = ALU_FUNCT;
        state_d     = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o2  = REG_DST_RD;
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o3   = ALU_SUB;
        pc_src_o2   = PC_SRC_ALUOUT;
        branch_o    = (op_i6 == OP_BEQ);
        branch_ne_o = (op_i6 == OP_BNE);
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_IMM_EXEC: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = SRC_B_IMM;
        case (op_i6)
          OP_SLTI: alu_op_o3 = ALU_SLT;
          OP_ANDI: alu_op_o3 = ALU_AND;
          OP_ORI:  alu_op_o3 = ALU_OR;
          default: alu_op_o3 = ALU_ADD;
        endcase
        imm_zext_o = (op_i6 == OP_ANDI) || (op_i6 == OP_ORI);
        state_d    = ST_IMM_WB;
      end
      ST_IMM_WB: begin
        reg_write_o = 1'b1;
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src_o2  = PC_SRC_JUMP;
        pc_write_o = 1'b1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_JAL: begin
        // PC already advanced in FETCH, so the link value is the current PC
        pc_src_o2     = PC_SRC_JUMP;
        pc_write_o    = 1'b1;
        reg_write_o   = 1'b1;
        reg_dst_o2    = REG_DST_RA;
        mem_to_reg_o2 = M2R_PC;
        retire        = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_TRAP: begin
        trap_o = 1'b1;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  // State and retired-instruction registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  assign state_o4  = state_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_mcp_controller_fsm_v2.sv
// Self-checking bench for mcp_controller_fsm_v2 (default parameters).
module tb_mcp_controller_fsm_v2;
  import mcp_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  logic        mem_ready_i;
  logic [5:0]  op_i6;
  logic        mem_req_o, instr_or_data_o, ir_write_o, mem_write_o, pc_write_o;
  logic        branch_o, branch_ne_o, reg_write_o, alu_src_a_o, imm_zext_o, trap_o;
  logic [1:0]  reg_dst_o2, mem_to_reg_o2, pc_src_o2, alu_src_b_o2;
  logic [2:0]  alu_op_o3;
  logic [3:0]  state_o4;
  logic [31:0] retired_o;

  mcp_controller_fsm_v2 dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .op_i6           (op_i6),
    .mem_ready_i     (mem_ready_i),
    .mem_req_o       (mem_req_o),
    .instr_or_data_o (instr_or_data_o),
    .ir_write_o      (ir_write_o),
    .mem_write_o     (mem_write_o),
    .pc_write_o      (pc_write_o),
    .branch_o        (branch_o),
    .branch_ne_o     (branch_ne_o),
    .reg_write_o     (reg_write_o),
    .reg_dst_o2      (reg_dst_o2),
    .mem_to_reg_o2   (mem_to_reg_o2),
    .pc_src_o2       (pc_src_o2),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o2    (alu_src_b_o2),
    .alu_op_o3       (alu_op_o3),
    .imm_zext_o      (imm_zext_o),
    .trap_o          (trap_o),
    .state_o4        (state_o4),
    .retired_o       (retired_o)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       req, iord, irw, memw, pcw, br, brne, regw;
    logic [1:0] rdst, m2r, pcsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic       zext, trap;
  } obs_t;

  obs_t obs;
  assign obs = {state_o4, mem_req_o, instr_or_data_o, ir_write_o, mem_write_o,
                pc_write_o, branch_o, branch_ne_o, reg_write_o, reg_dst_o2,
                mem_to_reg_o2, pc_src_o2, alu_src_a_o, alu_src_b_o2, alu_op_o3,
                imm_zext_o, trap_o};

  // Scoreboard state
  logic [25:0] exp_q[$];
  logic [31:0] ret_q[$];
  logic [31:0] exp_ret;
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Reference control table, written with literal encodings
  function automatic obs_t exp_vec(input state_t st, input logic [5:0] op, input logic rdy);
    obs_t e;
    e    = '0;
    e.st = st;
    case (st)
      ST_FETCH:     begin e.req = 1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      ST_DECODE:    begin e.srcb = 2'b11; end
      ST_MEM_ADR:   begin e.srca = 1; e.srcb = 2'b10; end
      ST_MEM_READ:  begin e.req = 1; e.iord = 1; end
      ST_MEM_WB:    begin e.regw = 1; e.m2r = 2'b01; end
      ST_MEM_WRITE: begin e.req = 1; e.iord = 1; e.memw = 1; end
      ST_EXECUTE:   begin e.srca = 1; e.aluop = 3'b010; end
      ST_ALU_WB:    begin e.regw = 1; e.rdst = 2'b01; end
      ST_BRANCH: begin
        e.srca = 1; e.aluop = 3'b001; e.pcsrc = 2'b01;
        e.br = (op == 6'b000100); e.brne = (op == 6'b000101);
      end
      ST_IMM_EXEC: begin
        e.srca = 1; e.srcb = 2'b10;
        case (op)
          6'b001010: e.aluop = 3'b101;
          6'b001100: begin e.aluop = 3'b011; e.zext = 1; end
          6'b001101: begin e.aluop = 3'b100; e.zext = 1; end
          default:   e.aluop = 3'b000;
        endcase
      end
      ST_IMM_WB: begin e.regw = 1; end
      ST_JUMP:   begin e.pcsrc = 2'b10; e.pcw = 1; end
      ST_JAL: begin
        e.pcsrc = 2'b10; e.pcw = 1; e.regw = 1; e.rdst = 2'b10; e.m2r = 2'b10;
      end
      ST_TRAP: begin e.trap = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit retires(input state_t st, input logic rdy);
    return (st == ST_MEM_WB) || (st == ST_ALU_WB) || (st == ST_BRANCH) ||
           (st == ST_IMM_WB) || (st == ST_JUMP) || (st == ST_JAL) ||
           ((st == ST_MEM_WRITE) && rdy);
  endfunction

  // Driver: one cycle in an expected state; called at posedge+1
  task automatic step(input state_t st, input logic [5:0] op, input logic rdy);
    op_i6       = op;
    mem_ready_i = rdy;
    exp_q.push_back(exp_vec(st, op, rdy));
    ret_q.push_back(exp_ret);
    @(negedge clk);
    check_eq($sformatf("ctl_%s", st.name()), obs, exp_q.pop_front());
    check_eq($sformatf("retired_%s", st.name()), retired_o, ret_q.pop_front());
    if (retires(st, rdy)) exp_ret = exp_ret + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i     = 1'b1;
    mem_ready_i = 1'($urandom_range(0, 1));
    #1;
    check_eq("rst_ctl", obs, exp_vec(ST_FETCH, op_i6, mem_ready_i));
    check_eq("rst_retired", retired_o, 0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    exp_ret = 0;
  endtask

  // One instruction from FETCH with wf fetch waits and wm memory waits
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    for (int i = 0; i < wf; i++) step(ST_FETCH, op, 1'b0);
    step(ST_FETCH, op, 1'b1);
    step(ST_DECODE, op, 1'($urandom_range(0, 1)));
    case (op)
      OP_LW: begin
        step(ST_MEM_ADR, op, 1'b1);
        for (int i = 0; i < wm; i++) step(ST_MEM_READ, op, 1'b0);
        step(ST_MEM_READ, op, 1'b1);
        step(ST_MEM_WB, op, 1'($urandom_range(0, 1)));
      end
      OP_SW: begin
        step(ST_MEM_ADR, op, 1'b1);
        for (int i = 0; i < wm; i++) step(ST_MEM_WRITE, op, 1'b0);
        step(ST_MEM_WRITE, op, 1'b1);
      end
      OP_RTYPE: begin
        step(ST_EXECUTE, op, 1'($urandom_range(0, 1)));
        step(ST_ALU_WB, op, 1'($urandom_range(0, 1)));
      end
      OP_BEQ, OP_BNE: step(ST_BRANCH, op, 1'($urandom_range(0, 1)));
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        step(ST_IMM_EXEC, op, 1'($urandom_range(0, 1)));
        step(ST_IMM_WB, op, 1'($urandom_range(0, 1)));
      end
      OP_J:   step(ST_JUMP, op, 1'($urandom_range(0, 1)));
      OP_JAL: step(ST_JAL, op, 1'($urandom_range(0, 1)));
      default: begin
        for (int i = 0; i < 4; i++) step(ST_TRAP, op, 1'($urandom_range(0, 1)));
        do_reset();
      end
    endcase
  endtask

  logic [5:0] legal_ops [11];

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    legal_ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
                  OP_ANDI, OP_ORI, OP_J, OP_JAL};
    reset_i     = 1'b1;
    mem_ready_i = 1'b1;
    op_i6       = OP_RTYPE;
    exp_ret     = 0;
    repeat (2) @(negedge clk);
    check_eq("reset_ctl", obs, exp_vec(ST_FETCH, OP_RTYPE, 1'b1));
    check_eq("reset_retired", retired_o, 0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    // Directed instructions
    run_instr(OP_LW, 0, 0);
    check_eq("lw_retired_one", retired_o, 1);
    run_instr(OP_SW, 0, 3);
    run_instr(OP_RTYPE, 0, 0);
    run_instr(OP_BNE, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_ADDI, 0, 0);
    run_instr(OP_SLTI, 0, 0);
    run_instr(OP_ANDI, 0, 0);
    run_instr(OP_ORI, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_JAL, 0, 0);

    // Random legal instructions with random memory stalls
    for (int n = 0; n < 24; n++) begin
      run_instr(legal_ops[$urandom_range(0, 10)], $urandom_range(0, 6), $urandom_range(0, 6));
    end

    // Ready on the 16th wait cycle still advances
    run_instr(OP_J, 15, 0);
    run_instr(OP_SW, 0, 15);
    run_instr(OP_LW, 0, 15);

    // Illegal opcode traps until reset
    run_instr(6'b111111, 0, 0);

    // FETCH timeout after 16 wait cycles
    for (int i = 0; i < 16; i++) step(ST_FETCH, OP_LW, 1'b0);
    step(ST_TRAP, OP_LW, 1'b1);
    step(ST_TRAP, OP_LW, 1'b0);
    do_reset();

    // MEM_READ timeout
    step(ST_FETCH, OP_LW, 1'b1);
    step(ST_DECODE, OP_LW, 1'b1);
    step(ST_MEM_ADR, OP_LW, 1'b1);
    for (int i = 0; i < 16; i++) step(ST_MEM_READ, OP_LW, 1'b0);
    step(ST_TRAP, OP_LW, 1'b1);
    do_reset();

    // Asynchronous reset in the middle of MEM_READ
    run_instr(OP_ADDI, 0, 0);
    step(ST_FETCH, OP_LW, 1'b1);
    step(ST_DECODE, OP_LW, 1'b1);
    step(ST_MEM_ADR, OP_LW, 1'b1);
    mem_ready_i = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_state", state_o4, 4'd3);
    #2;
    do_reset();
    run_instr(OP_ORI, 1, 0);
    check_eq("post_rst_retired", retired_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
